// File: rtl/fnd_scan_ctrl.sv
// Multiplexed common-anode 7-segment scan controller.
// Scans NUM_DIGITS digits, one per SCAN_DIV-cycle slot. Each slot starts with
// BLANK_CYC cycles where every common is off, so no digit ghosts. Digit data is
// double-buffered and only swaps at frame wrap, so a frame never shows a mix of
// old and new data. Every digit has its own decimal point, blank and blink
// control. Leading-zero blanking is optional.
module fnd_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYC    = 4,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [4*NUM_DIGITS-1:0]   i_bcd,
    input  logic [NUM_DIGITS-1:0]     i_dp,
    input  logic [NUM_DIGITS-1:0]     i_blank,
    input  logic [NUM_DIGITS-1:0]     i_blink,
    input  logic                      i_lzb_en,
    input  logic                      i_load,
    output logic [7:0]                o_fndFont,
    output logic [NUM_DIGITS-1:0]     o_fndCom,
    output logic                      o_frame_done
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYC);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [FW-1:0] BLINK_LAST = FW'(BLINK_FRAMES - 1);

    // Segments {g,f,e,d,c,b,a} for a hex nibble. The output is active-low.
    function automatic logic [6:0] seg_font(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    logic [PW-1:0]           presc_r;
    logic [IW-1:0]           idx_r;
    logic [FW-1:0]           frame_cnt_r;
    logic                    phase_r;
    logic [4*NUM_DIGITS-1:0] stage_bcd_r, disp_bcd_r;
    logic [NUM_DIGITS-1:0]   stage_dp_r, disp_dp_r;
    logic [NUM_DIGITS-1:0]   stage_blank_r, disp_blank_r;
    logic [NUM_DIGITS-1:0]   stage_blink_r, disp_blink_r;
    logic                    pending_r;

    logic                    tick_s;
    logic                    wrap_s;
    logic [3:0]              cur_nib_s;
    logic [NUM_DIGITS-1:0]   lzb_off_s;
    logic                    digit_off_s;
    logic [7:0]              font_s;
    logic [NUM_DIGITS-1:0]   com_s;

    assign tick_s    = (presc_r == PRESC_LAST);
    assign wrap_s    = tick_s && (idx_r == IDX_LAST);
    assign cur_nib_s = disp_bcd_r[{idx_r, 2'b00} +: 4];

    // A digit is a leading zero when it and every digit above it are zero. Digit 0 is never blanked this way.
    always_comb begin
        logic zero_run;
        lzb_off_s = '0;
        zero_run  = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run     = zero_run & (disp_bcd_r[4*k +: 4] == 4'h0);
            lzb_off_s[k] = zero_run & i_lzb_en;
        end
    end

    assign digit_off_s = disp_blank_r[idx_r]
                       | (disp_blink_r[idx_r] & phase_r)
                       | lzb_off_s[idx_r];
    assign font_s      = digit_off_s ? 8'hFF : {~disp_dp_r[idx_r], seg_font(cur_nib_s)};

    // Common select: all commons stay off during the dead time at the start of a slot.
    always_comb begin
        com_s = '1;
        if (presc_r < BLANK_END) begin
            com_s = '1;
        end else begin
            com_s[idx_r] = 1'b0;
        end
    end

    // Slot prescaler and digit index.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_r <= '0;
            idx_r   <= '0;
        end else if (tick_s) begin
            presc_r <= '0;
            if (idx_r == IDX_LAST) begin
                idx_r <= '0;
            end else begin
                idx_r <= idx_r + IW'(1);
            end
        end else begin
            presc_r <= presc_r + PW'(1);
        end
    end

    // Blink phase flips after every BLINK_FRAMES frame wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_r <= '0;
            phase_r     <= 1'b0;
        end else if (wrap_s) begin
            if (frame_cnt_r == BLINK_LAST) begin
                frame_cnt_r <= '0;
                phase_r     <= ~phase_r;
            end else begin
                frame_cnt_r <= frame_cnt_r + FW'(1);
            end
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end

    // Double buffer. At a wrap the display takes the old staging, and a load on that same cycle stays pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_bcd_r   <= '0;
            stage_dp_r    <= '0;
            stage_blank_r <= '0;
            stage_blink_r <= '0;
            disp_bcd_r    <= '0;
            disp_dp_r     <= '0;
            disp_blank_r  <= '0;
            disp_blink_r  <= '0;
            pending_r     <= 1'b0;
        end else begin
            if (wrap_s && pending_r) begin
                disp_bcd_r   <= stage_bcd_r;
                disp_dp_r    <= stage_dp_r;
                disp_blank_r <= stage_blank_r;
                disp_blink_r <= stage_blink_r;
            end
            if (i_load) begin
                stage_bcd_r   <= i_bcd;
                stage_dp_r    <= i_dp;
                stage_blank_r <= i_blank;
                stage_blink_r <= i_blink;
                pending_r     <= 1'b1;
            end else if (wrap_s) begin
                pending_r     <= 1'b0;
            end else begin
                pending_r     <= pending_r;
            end
        end
    end

    // Registered pin drivers.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_fndCom     <= '1;
            o_fndFont    <= 8'hFF;
            o_frame_done <= 1'b0;
        end else begin
            o_fndCom     <= com_s;
            o_fndFont    <= font_s;
            o_frame_done <= wrap_s;
        end
    end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Self-checking bench for fnd_scan_ctrl (4 digits, 8-cycle slots, 2-cycle dead time, 2-frame blink).
// The expected output for each cycle comes from the cycle count since reset, using plain arithmetic.
module tb_fnd_scan_ctrl;

    localparam int N  = 4;
    localparam int S  = 8;
    localparam int BC = 2;
    localparam int BF = 2;
    localparam int FR = S * N;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] i_bcd;
    logic [3:0]  i_dp, i_blank, i_blink;
    logic        i_lzb_en, i_load;
    logic [7:0]  o_fndFont;
    logic [3:0]  o_fndCom;
    logic        o_frame_done;

    always #5 clk = ~clk;

    fnd_scan_ctrl #(
        .NUM_DIGITS(N), .SCAN_DIV(S), .BLANK_CYC(BC), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .reset(reset), .i_bcd(i_bcd), .i_dp(i_dp), .i_blank(i_blank),
        .i_blink(i_blink), .i_lzb_en(i_lzb_en), .i_load(i_load),
        .o_fndFont(o_fndFont), .o_fndCom(o_fndCom), .o_frame_done(o_frame_done)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: cycles since reset, staging and displayed data
    int          t = 0;
    logic [15:0] ms_bcd = '0, md_bcd = '0;
    logic [3:0]  ms_dp = '0, ms_blank = '0, ms_blink = '0;
    logic [3:0]  md_dp = '0, md_blank = '0, md_blink = '0;
    bit          m_pend = 1'b0;
    logic [7:0]  font_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                   8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Frame capture bookkeeping
    logic [7:0]  cap_font [N];
    int          fd_cnt, blank_cnt, first_digit;

    task automatic clear_cap();
        for (int k = 0; k < N; k++) cap_font[k] = 8'h00;
        fd_cnt = 0; blank_cnt = 0; first_digit = -1;
    endtask

    // One clock cycle: predict the outputs, advance the DUT and the model, then compare.
    task automatic step();
        int pre, idx, ph, nib;
        logic [3:0] e_com;
        logic [7:0] e_font;
        logic       e_fd, off;
        if (reset) begin
            e_com = 4'hF; e_font = 8'hFF; e_fd = 1'b0;
        end else begin
            pre   = t % S;
            idx   = (t / S) % N;
            ph    = ((t / FR) / BF) % 2;
            e_com = (pre < BC) ? 4'hF : ~(4'b0001 << idx);
            nib   = int'((md_bcd >> (4 * idx)) & 16'h000F);
            e_font = font_tab[nib];
            if (md_dp[idx]) e_font[7] = 1'b0;
            off = md_blank[idx] || (md_blink[idx] && ph == 1) ||
                  (i_lzb_en && idx >= 1 && (md_bcd >> (4 * idx)) == 16'h0000);
            if (off) e_font = 8'hFF;
            e_fd = ((t % FR) == FR - 1);
        end
        @(posedge clk);
        #1;
        if (reset) begin
            t = 0; m_pend = 1'b0;
            ms_bcd = '0; ms_dp = '0; ms_blank = '0; ms_blink = '0;
            md_bcd = '0; md_dp = '0; md_blank = '0; md_blink = '0;
        end else begin
            if ((t % FR) == FR - 1 && m_pend) begin
                md_bcd = ms_bcd; md_dp = ms_dp; md_blank = ms_blank; md_blink = ms_blink;
                m_pend = 1'b0;
            end
            if (i_load) begin
                ms_bcd = i_bcd; ms_dp = i_dp; ms_blank = i_blank; ms_blink = i_blink;
                m_pend = 1'b1;
            end
            t++;
        end
        chk("com", o_fndCom, e_com);
        chk("font", o_fndFont, e_font);
        chk("frame_done", o_frame_done, e_fd);
        if (o_fndCom == 4'hF) blank_cnt++;
        if (o_frame_done) fd_cnt++;
        for (int k = 0; k < N; k++) begin
            if (!o_fndCom[k]) begin
                cap_font[k] = o_fndFont;
                if (first_digit < 0) first_digit = k;
            end
        end
    endtask

    task automatic load_data(input logic [15:0] bcd, input logic [3:0] dp,
                             input logic [3:0] blank, input logic [3:0] blink);
        i_bcd = bcd; i_dp = dp; i_blank = blank; i_blink = blink; i_load = 1'b1;
        step();
        i_load = 1'b0;
    endtask

    task automatic to_frame_start();
        while ((t % FR) != 0) step();
    endtask

    task automatic capture_frame();
        clear_cap();
        repeat (FR) step();
    endtask

    logic [7:0] b0 [4];
    int nff, nc0;

    initial begin
        reset = 1'b1; i_bcd = '0; i_dp = '0; i_blank = '0; i_blink = '0;
        i_lzb_en = 1'b0; i_load = 1'b0;
        step(); step();
        chk("reset_com", o_fndCom, 4'hF);
        chk("reset_font", o_fndFont, 8'hFF);
        chk("reset_fd", o_frame_done, 1'b0);
        reset = 1'b0;

        // Basic digits 1234
        load_data(16'h1234, 4'h0, 4'h0, 4'h0);
        to_frame_start();
        capture_frame();
        chk("d0_1234", cap_font[0], 8'h99);
        chk("d1_1234", cap_font[1], 8'hB0);
        chk("d2_1234", cap_font[2], 8'hA4);
        chk("d3_1234", cap_font[3], 8'hF9);
        chk("fd_per_frame", fd_cnt, 1);
        chk("deadtime_cycles", blank_cnt, 2 * N);

        // Leading-zero blanking on, then off
        i_lzb_en = 1'b1;
        load_data(16'h0050, 4'h0, 4'h0, 4'h0);
        to_frame_start();
        capture_frame();
        chk("lzb_d3", cap_font[3], 8'hFF);
        chk("lzb_d2", cap_font[2], 8'hFF);
        chk("lzb_d1", cap_font[1], 8'h92);
        chk("lzb_d0", cap_font[0], 8'hC0);
        i_lzb_en = 1'b0;
        capture_frame();
        chk("nolzb_d3", cap_font[3], 8'hC0);
        chk("nolzb_d2", cap_font[2], 8'hC0);

        // Decimal point on digit 2
        load_data(16'h0000, 4'b0100, 4'h0, 4'h0);
        to_frame_start();
        capture_frame();
        chk("dp_d2", cap_font[2], 8'h40);
        chk("dp_d0", cap_font[0], 8'hC0);
        chk("dp_d3", cap_font[3], 8'hC0);

        // Blink on digit 0
        load_data(16'h0000, 4'h0, 4'h0, 4'b0001);
        to_frame_start();
        nff = 0; nc0 = 0;
        for (int f = 0; f < 4; f++) begin
            capture_frame();
            b0[f] = cap_font[0];
            if (b0[f] == 8'hFF) nff++;
            if (b0[f] == 8'hC0) nc0++;
            chk("blink_d1_steady", cap_font[1], 8'hC0);
        end
        chk("blink_off_frames", nff, 2);
        chk("blink_on_frames", nc0, 2);
        chk("blink_alternates", (b0[0] != b0[2]) ? 1 : 0, 1);

        // Load exactly on the wrap cycle
        load_data(16'h0000, 4'h0, 4'h0, 4'h0);
        to_frame_start();
        repeat (3) step();
        load_data(16'h1111, 4'h0, 4'h0, 4'h0);
        while ((t % FR) != FR - 1) step();
        load_data(16'h9999, 4'h0, 4'h0, 4'h0);
        capture_frame();
        for (int k = 0; k < N; k++) chk("wrapload_old", cap_font[k], 8'hF9);
        capture_frame();
        for (int k = 0; k < N; k++) chk("wrapload_new", cap_font[k], 8'h90);

        // Reset in the middle of the digit-2 slot
        while ((t % FR) != 2 * S + 4) step();
        reset = 1'b1;
        step();
        chk("midreset_com", o_fndCom, 4'hF);
        chk("midreset_font", o_fndFont, 8'hFF);
        chk("midreset_fd", o_frame_done, 1'b0);
        reset = 1'b0;
        capture_frame();
        chk("restart_digit0", first_digit, 0);
        for (int k = 0; k < N; k++) chk("restart_disp_zero", cap_font[k], 8'hC0);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            i_bcd = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       i_bcd = i_bcd & 16'h000F;
                1:       i_bcd = i_bcd & 16'h00FF;
                2:       i_bcd = i_bcd & 16'h0FFF;
                default: i_bcd = i_bcd;
            endcase
            i_dp     = 4'($urandom);
            i_blank  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            i_blink  = ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'h0;
            if ($urandom_range(0, 63) == 0) i_lzb_en = ~i_lzb_en;
            i_load   = ($urandom_range(0, 15) == 0);
            reset    = ($urandom_range(0, 599) == 0);
            step();
        end
        reset = 1'b0; i_load = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fnd_scan_ctrl.md
Name: fnd_scan_ctrl

Overview:
Parametrised multiplexed 7-segment scan controller for common-anode FND modules. It succeeds the fixed 4-digit/8-slot FND controller with the following additions:
- N digits
- internal prescaler
- tear-free double-buffered digit data
- per-digit decimal point, blank and blink
- optional leading-zero blanking
- anti-ghost dead time between digit switches

It sits between the time/stopwatch datapath (which supplies packed BCD nibbles) and the board FND pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (2..8)
SCAN_DIV, 100000, clk cycles per digit slot (>= 4)
BLANK_CYC, 4, dead cycles at start of each slot with all commons off (< SCAN_DIV)
BLINK_FRAMES, 64, full scan frames per blink half-period (>= 1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
i_bcd  in  4*NUM_DIGITS  packed nibbles; digit k = i_bcd[4k+3:4k], digit 0 is rightmost
i_dp  in  NUM_DIGITS  decimal point enable per digit
i_blank  in  NUM_DIGITS  force digit off
i_blink  in  NUM_DIGITS  digit blinks
i_lzb_en  in  1  leading-zero blanking enable
i_load  in  1  capture i_bcd/i_dp/i_blank/i_blink into staging
o_fndFont  out  8  {dp,g,f,e,d,c,b,a}, active-low
o_fndCom  out  NUM_DIGITS  digit commons, active-low one-hot
o_frame_done  out  1  one-cycle pulse at each frame wrap

Behaviour:
- One clock (clk). Reset is synchronous and active-high. All state changes on the clk rising edge.
- Reset values:
  - prescaler = 0, digit index = 0, blink phase = 0
  - staging and display registers = 0, pending = 0
  - o_fndCom = all 1, o_fndFont = 8'hFF, o_frame_done = 0
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - tick = (prescaler == SCAN_DIV-1).
- Digit index:
  - On tick, index increments; NUM_DIGITS-1 wraps to 0.
  - On that wrap, o_frame_done = 1 for exactly the next cycle.
- Outputs are registered and reflect the index and prescaler values of the previous cycle.
  - o_fndCom is all 1 while prescaler < BLANK_CYC.
  - Otherwise o_fndCom[index] = 0 and all other bits are 1.
  - o_fndFont updates in the same cycle as o_fndCom.
- Double buffer:
  - i_load = 1 copies all four inputs into staging and sets pending.
  - At frame wrap (tick with index == NUM_DIGITS-1), if pending, staging is copied to display and pending is cleared.
  - i_load asserted in the same cycle as a frame wrap: the wrap uses the old staging contents, the new values are captured into staging, and pending remains 1, so the new data is displayed one frame later.
  - Repeated i_load before a wrap: the last capture wins.
- Font, from the display register:
  - 0..9 → C0,F9,A4,B0,99,92,82,F8,80,90
  - A..F → 88,83,C6,A1,86,8E
  - dp set clears bit 7.
- Digit off (font = 8'hFF, dp also off) when any of the following holds:
  - blank[k] = 1
  - blink[k] = 1 and blink phase = 1
  - LZB applies to digit k
  - The common is still driven for a digit that is off.
- LZB: when i_lzb_en = 1, digit k (k >= 1) is off if the nibbles of k and every higher digit are all 0. Digit 0 is never LZB-blanked.
- Blink phase toggles after every BLINK_FRAMES frame wraps.
- Reset mid-frame: all outputs return to reset values on the next edge. Scanning restarts at digit 0 with the prescaler at 0.

Test Plan:
- Config NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYC=2, BLINK_FRAMES=2. Reset, then i_load with i_bcd=16'h1234, i_dp=0 → after the first frame wrap, slots show:
  - digit0 font 99, com 1110
  - digit1 font B0, com 1101
  - digit2 font A4
  - digit3 font F9
  - com = 1111 for the first 2 cycles of each 8-cycle slot; o_frame_done pulses once per 32 cycles.
- i_bcd=16'h0050, i_lzb_en=1 → digit3 and digit2 font FF, digit1 92, digit0 C0.
- Same data with i_lzb_en=0 → digit3 and digit2 show C0.
- i_dp=4'b0100, i_bcd=16'h0000 → digit2 font 40, others C0.
- i_blink=4'b0001 → digit0 alternates C0 / FF every 2 frames (64 cycles); other digits steady.
- i_load on the exact frame-wrap cycle with new data 16'h9999 → the next frame still shows old data, the following frame shows 90 on all digits.
- Assert reset mid-slot of digit2 → next cycle com = 1111, font = FF, frame_done = 0; scanning restarts at digit0 and the display register reads 0.
